// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage with a 2-entry {pc, instr} buffer.
// fetch_pc drives the instruction memory. Each fetched word is pushed into
// the buffer, and decode pops from the buffer head. A redirect flushes the
// buffer and loads a word-aligned target.
// Optional build macro: IFETCH_MISALIGN_CHK_EN enables the sticky
// misaligned-redirect flag. When it is undefined, the low target bits are
// dropped and if_misalign is tied to 0.
module ifetch_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  input  logic        redir_en,
  input  logic [31:0] redir_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_misalign
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q    [2];
  logic [31:0] pc_d    [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [1:0]  count_q, count_d;
  logic        pop, push;

  assign im_addr  = fetch_pc_q[11:2];
  assign if_valid = (count_q != 2'd0);
  assign if_pc    = if_valid ? pc_q[0]    : '0;
  assign if_instr = if_valid ? instr_q[0] : '0;

  // Redirect wins over push/pop; slot 0 is always the head, so a pop shifts slot 1 down
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pop        = if_valid && id_ready && !redir_en;
    push       = ((count_q < 2'd2) || (if_valid && id_ready)) && !redir_en;
    if (redir_en) begin
      count_d    = '0;
      fetch_pc_d = {redir_pc[31:2], 2'b00};
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc_d[0]    = fetch_pc_q;
            instr_d[0] = im_dout;
          end else begin
            pc_d[1]    = fetch_pc_q;
            instr_d[1] = im_dout;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc_d[0]    = pc_q[1];
          instr_d[0] = instr_q[1];
          count_d    = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc_d[0]    = fetch_pc_q;
            instr_d[0] = im_dout;
          end else begin
            pc_d[0]    = pc_q[1];
            instr_d[0] = instr_q[1];
            pc_d[1]    = fetch_pc_q;
            instr_d[1] = im_dout;
          end
        end
        default: ;
      endcase
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  // State registers for fetch_pc, the buffer slots and the occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= '0;
      count_q    <= '0;
      pc_q[0]    <= '0;
      pc_q[1]    <= '0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign if_misalign = misalign_q;

  // Sticky flag: each redirect sets it or clears it according to its alignment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redir_en) begin
      misalign_q <= (redir_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redir_pc[1:0];
  assign if_misalign      = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven directed test for ifetch_unit.
// Memory model: word k holds the value k.
module tb_ifetch_unit;

`ifdef IFETCH_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic        redir_en = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_misalign;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  ifetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .im_addr    (im_addr),
    .im_dout    (im_dout),
    .redir_en   (redir_en),
    .redir_pc   (redir_pc),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  assign im_dout = {22'b0, im_addr};

  typedef struct {
    bit          r;
    bit          d;
    logic [31:0] rp;
    bit          rd;
    bit          v;
    logic [31:0] p;
    logic [31:0] i;
    logic [9:0]  a;
    bit          m;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(bit r, bit d, logic [31:0] rp, bit rd,
                              bit v, logic [31:0] p, logic [31:0] i,
                              logic [9:0] a, bit m);
    vec_t t;
    t.r = r; t.d = d; t.rp = rp; t.rd = rd;
    t.v = v; t.p = p; t.i = i; t.a = a; t.m = m;
    return t;
  endfunction

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int unsigned idx, input bit v,
                             input logic [31:0] p, input logic [31:0] i,
                             input logic [9:0] a, input bit m);
    chk("if_valid", idx, {31'b0, if_valid}, {31'b0, v});
    chk("if_pc", idx, if_pc, p);
    chk("if_instr", idx, if_instr, i);
    chk("im_addr", idx, {22'b0, im_addr}, {22'b0, a});
    chk("if_misalign", idx, {31'b0, if_misalign}, {31'b0, m});
  endtask

  initial begin
    // Each row gives the inputs for one cycle and the outputs expected in that cycle.
    // Columns: rst redir redir_pc rdy | valid pc instr addr misalign
    vecs[0]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h0,   0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h0,   0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 1, 32'h0,        32'h0,   10'h1,   0);
    vecs[3]  = mk(0, 0, 32'h0,        1, 1, 32'h4,        32'h1,   10'h2,   0);
    vecs[4]  = mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h0,   0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,   10'h0,   0);
    vecs[6]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,   10'h1,   0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,   10'h2,   0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,   10'h2,   0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        32'h0,   10'h2,   0);
    vecs[10] = mk(0, 0, 32'h0,        1, 1, 32'h0,        32'h0,   10'h2,   0);
    vecs[11] = mk(0, 0, 32'h0,        1, 1, 32'h4,        32'h1,   10'h3,   0);
    vecs[12] = mk(0, 0, 32'h0,        0, 1, 32'h8,        32'h2,   10'h4,   0);
    vecs[13] = mk(0, 1, 32'h40,       0, 1, 32'h8,        32'h2,   10'h4,   0);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,   10'h10,  0);
    vecs[15] = mk(0, 0, 32'h0,        1, 1, 32'h40,       32'd16,  10'h11,  0);
    vecs[16] = mk(0, 0, 32'h0,        1, 1, 32'h44,       32'd17,  10'h12,  0);
    vecs[17] = mk(0, 1, 32'h100,      1, 1, 32'h48,       32'd18,  10'h13,  0);
    vecs[18] = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h40,  0);
    vecs[19] = mk(0, 1, 32'h42,       1, 1, 32'h100,      32'd64,  10'h41,  0);
    vecs[20] = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h10,  1);
    vecs[21] = mk(0, 1, 32'h80,       1, 1, 32'h40,       32'd16,  10'h11,  1);
    vecs[22] = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h20,  0);
    vecs[23] = mk(0, 1, 32'h200,      1, 1, 32'h80,       32'd32,  10'h21,  0);
    vecs[24] = mk(0, 1, 32'h300,      1, 0, 32'h0,        32'h0,   10'h80,  0);
    vecs[25] = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'hC0,  0);
    vecs[26] = mk(0, 1, 32'hFFFFFFFC, 1, 1, 32'h300,      32'hC0,  10'hC1,  0);
    vecs[27] = mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   10'h3FF, 0);
    vecs[28] = mk(0, 0, 32'h0,        1, 1, 32'hFFFFFFFC, 32'h3FF, 10'h0,   0);
    vecs[29] = mk(0, 0, 32'h0,        1, 1, 32'h0,        32'h0,   10'h1,   0);

    for (int unsigned k = 0; k < 30; k++) begin
      @(negedge clk);
      rst      = vecs[k].r;
      redir_en = vecs[k].d;
      redir_pc = vecs[k].rp;
      id_ready = vecs[k].rd;
      #1;
      chk_outputs(k, vecs[k].v, vecs[k].p, vecs[k].i, vecs[k].a,
                  vecs[k].m & MIS);
    end

    // Asynchronous reset raised between clock edges while the buffer holds data.
    @(negedge clk);
    rst = 1'b0; redir_en = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 100, {31'b0, if_valid}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 101, {31'b0, if_valid}, 32'd0);
    chk("async_rst_pc", 102, if_pc, 32'h0);
    chk("async_rst_addr", 103, {22'b0, im_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0; id_ready = 1'b1;
    #1;
    chk("post_rst_valid", 104, {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("first_valid", 105, {31'b0, if_valid}, 32'd1);
    chk("first_pc", 106, if_pc, 32'h0);
    @(negedge clk);
    #1;
    chk("second_pc", 107, if_pc, 32'h4);
    chk("second_instr", 108, if_instr, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 im_addr  output  10  word address to instruction memory, equal to fetch_pc[11:2].
REQ-005 im_dout  input  32  instruction word from memory, combinational on im_addr, same cycle.
REQ-006 redir_en  input  1  branch/jump redirect request from execute.
REQ-007 redir_pc  input  32  redirect target byte address.
REQ-008 id_ready  input  1  decode accepts the head instruction this cycle.
REQ-009 if_valid  output  1  head instruction valid.
REQ-010 if_instr  output  32  head instruction word.
REQ-011 if_pc  output  32  byte address of the head instruction.
REQ-012 if_misalign  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-013 The block SHALL hold a 32-bit fetch_pc register and a 2-entry FIFO of {pc, instr} pairs with a 2-bit count.
REQ-014 Outputs SHALL come from the FIFO head: if_valid = (count != 0); if_instr and if_pc are the head fields, and 0 when empty.
REQ-015 Pop SHALL occur at the clock edge when if_valid && id_ready.
REQ-016 Push of {fetch_pc, im_dout} SHALL occur at the clock edge when (count < 2 || pop) && !redir_en; on push, fetch_pc advances by 4, modulo 2^32.
REQ-017 Simultaneous push and pop SHALL leave count unchanged, and ordering SHALL be preserved.
REQ-018 When full without pop, fetch_pc and the FIFO SHALL hold; im_addr stays stable.
REQ-019 redir_en SHALL have priority over push and pop: at that edge count goes to 0, fetch_pc takes the aligned target, and the pop is ignored (decode does not consume).
REQ-020 Redirect latency SHALL be: redir_en in cycle N, im_addr shows the target in N+1, and if_valid=1 with the target instruction in N+2.
REQ-021 redir_en held for multiple cycles SHALL re-apply each cycle; no push occurs while it is asserted.
REQ-022 Address wrap SHALL be handled as follows: fetch_pc = 0xFFFF_FFFC pushes, then becomes 0x0000_0000 with no flag.
REQ-023 The FIFO SHALL never overflow or underflow; count stays in the range 0..2.

Reset
REQ-024 rst=1 SHALL immediately force: fetch_pc=0x0000_0000, count=0, if_valid=0, if_instr=0, if_pc=0, if_misalign=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered instructions.
REQ-026 The first push SHALL occur on the first rising edge after rst deasserts; if_valid=1 with pc 0 appears in the following cycle.

Configuration
REQ-027 Macro IFETCH_MISALIGN_CHK_EN SHALL select misaligned-redirect checking.
REQ-028 With IFETCH_MISALIGN_CHK_EN defined, a redirect with redir_pc[1:0] != 0 SHALL set if_misalign=1.
REQ-029 With IFETCH_MISALIGN_CHK_EN defined, if_misalign SHALL remain set until reset or an aligned redirect.
REQ-030 With IFETCH_MISALIGN_CHK_EN defined, fetch_pc SHALL still load {redir_pc[31:2],2'b00}.
REQ-031 Without IFETCH_MISALIGN_CHK_EN, redir_pc[1:0] SHALL be silently masked and if_misalign SHALL be tied to 0.

Verification
REQ-032 Reset release with id_ready=1 and memory word k = k SHALL produce if_valid from cycle 2, with if_pc sequence 0,4,8,... and if_instr = if_pc/4.
REQ-033 id_ready=0 for 5 cycles SHALL give count=2, if_pc=0 held, and im_addr=2; on release SHALL produce pcs 0,4,8 on consecutive cycles with no gap and no duplicate.
REQ-034 redir_en with redir_pc=0x40 while full SHALL give if_valid=0 next cycle, then if_pc=0x40, then 0x44.
REQ-035 Redirect and id_ready=1 in the same cycle SHALL produce no pop, and the old head SHALL not be seen again.
REQ-036 redir_pc=0x42 SHALL give if_pc=0x40; if_misalign=1 with the macro and 0 without; a following redirect to 0x80 SHALL clear it.
REQ-037 rst pulsed mid-stream while if_valid=1 SHALL drop if_valid immediately and restart the sequence at pc 0.
